// File: rtl/bcd_7seg_scanner_pkg.sv
// bcd_7seg_scanner_pkg: shared segment patterns, digit-index type and reset index
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package bcd_7seg_scanner_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [1:0] idx_t;

    // Starting at 3 makes the first tick after reset land on digit0.
    localparam idx_t IDX_RST = 2'd3;

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD digit to active-low 7-segment decoder
// Ports: bcd [3:0] digit in; seg [6:0] {g,f,e,d,c,b,a} active-low, dash for codes 10-15.
module bcd_to_7seg
    import bcd_7seg_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner: 4-digit multiplexed 7-segment driver with frame-synchronous display update
// Ports: clk; rst async active-low; bcd_in [15:0] four BCD digits (digit0 in [3:0]);
//        load strobe samples bcd_in; an [3:0] active-low digit enables;
//        seg [6:0] active-low {g,f,e,d,c,b,a}; frame pulses on the tick selecting digit0.
// Option: define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module bcd_7seg_scanner
    import bcd_7seg_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] pre;
    idx_t          idx, nidx;
    logic [15:0]   pending, disp, disp_nx;
    logic          pend_valid, tick, wrap, blank;
    logic [3:0]    digit;
    logic [6:0]    dec;

    assign tick = pre == PW'(SCAN_DIV - 1);
    assign nidx = idx + 2'd1;
    assign wrap = tick && idx == 2'd3;

    // The display register only moves on the wrap tick; a load on that very
    // tick bypasses the pending register so digit0 shows it immediately.
    assign disp_nx = !wrap ? disp : load ? bcd_in : pend_valid ? pending : disp;

    // Decode from the post-update display so digit0 reflects a wrap-time swap.
    assign digit = disp_nx[{nidx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic z1, z2, z3;
    assign z3    = disp_nx[15:12] == 4'd0;
    assign z2    = z3 && disp_nx[11:8] == 4'd0;
    assign z1    = z2 && disp_nx[7:4] == 4'd0;
    assign blank = nidx == 2'd3 ? z3 : nidx == 2'd2 ? z2 : nidx == 2'd1 ? z1 : 1'b0;
`else
    assign blank = 1'b0;
`endif

    bcd_to_7seg u_dec (
        .bcd (digit),
        .seg (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre        <= '0;
            idx        <= IDX_RST;
            pending    <= '0;
            pend_valid <= 1'b0;
            disp       <= '0;
            an         <= 4'hF;
            seg        <= SEG_BLANK;
            frame      <= 1'b0;
        end else begin
            pre   <= tick ? '0 : pre + 1'b1;
            frame <= wrap;
            disp  <= disp_nx;
            if (wrap) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pending    <= bcd_in;
                pend_valid <= 1'b1;
            end
            if (tick) begin
                idx <= nidx;
                an  <= ~(4'b0001 << nidx);
                seg <= blank ? SEG_BLANK : dec;
            end
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// tb_bcd_7seg_scanner: table-driven, directed and random checks against a cycle-count reference model
module tb_bcd_7seg_scanner;

    localparam int S = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] Z = LZB ? 7'b1111111 : 7'b1000000;

    typedef struct packed {
        logic [15:0]     val;
        logic [3:0][6:0] s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;

    bcd_7seg_scanner #(.SCAN_DIV(S)) dut (
        .clk    (clk),
        .rst    (rst),
        .bcd_in (bcd_in),
        .load   (load),
        .an     (an),
        .seg    (seg),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          n;
    logic [15:0] m_disp, m_last;
    bit          m_have;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_frame;
    logic [6:0]  pat [16];
    vec_t        tbl [8];

    function automatic logic [6:0] seg_of(logic [15:0] v, int k);
        int upper;
        upper = int'(v) >> (4 * k);
        if (LZB && k > 0 && upper == 0) return 7'b1111111;
        return pat[upper % 16];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(string tag);
        check({tag, " an"}, 32'(an), 32'(m_an));
        check({tag, " seg"}, 32'(seg), 32'(m_seg));
        check({tag, " frame"}, 32'(frame), 32'(m_frame));
    endtask

    task automatic model_reset();
        n = 0;
        m_disp = '0;
        m_last = '0;
        m_have = 1'b0;
        m_an = 4'hF;
        m_seg = 7'b1111111;
        m_frame = 1'b0;
    endtask

    // Edge n after reset release is a tick when n is a multiple of S;
    // tick t selects digit (t-1) mod 4, and digit0 ticks are frame boundaries.
    task automatic model_step(bit ld, logic [15:0] v);
        int d;
        bit tk, wr;
        n++;
        tk = (n % S) == 0;
        d = tk ? ((n / S) - 1) % 4 : 0;
        wr = tk && d == 0;
        if (wr) begin
            if (ld) m_disp = v;
            else if (m_have) m_disp = m_last;
            m_have = 1'b0;
        end else if (ld) begin
            m_last = v;
            m_have = 1'b1;
        end
        m_frame = wr;
        if (tk) begin
            m_an = 4'(~(4'b0001 << d));
            m_seg = seg_of(m_disp, d);
        end
    endtask

    task automatic cyc(bit ld, logic [15:0] v);
        load = ld;
        bcd_in = v;
        @(posedge clk);
        model_step(ld, v);
        @(negedge clk);
        load = 1'b0;
        check_out("model");
    endtask

    function automatic bit tick_next(int d);
        return ((n + 1) % S) == 0 && (((n + 1) / S) - 1) % 4 == d;
    endfunction

    task automatic go_to(int d);
        int g;
        g = 0;
        while (!tick_next(d) && g < 64) begin
            cyc(1'b0, 16'h0);
            g++;
        end
        if (g >= 64) begin
            errors++;
            $display("FAIL go_to digit %0d: no tick within 64 cycles", d);
        end
    endtask

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
        pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
        pat[8] = 7'b0000000; pat[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) pat[i] = 7'b0111111;

        tbl[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        tbl[1] = '{16'h5678, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
        tbl[2] = '{16'h9090, {7'b0010000, 7'b1000000, 7'b0010000, 7'b1000000}};
        tbl[3] = '{16'h00A5, {Z, Z, 7'b0111111, 7'b0010010}};
        tbl[4] = '{16'h0070, {Z, Z, 7'b1111000, 7'b1000000}};
        tbl[5] = '{16'hFBCD, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        tbl[6] = '{16'h0000, {Z, Z, Z, 7'b1000000}};
        tbl[7] = '{16'h0E00, {Z, 7'b0111111, 7'b1000000, 7'b1000000}};

        model_reset();
        repeat (2) @(negedge clk);
        check("reset an", 32'(an), 32'h0000000F);
        check("reset seg", 32'(seg), 32'h0000007F);
        check("reset frame", 32'(frame), 32'h0);
        rst = 1'b1;

        repeat (3) cyc(1'b0, 16'h0);
        check("idle an", 32'(an), 32'h0000000F);
        check("idle seg", 32'(seg), 32'h0000007F);
        cyc(1'b0, 16'h0);
        check("first tick an", 32'(an), 32'h0000000E);
        check("first tick seg", 32'(seg), 32'(7'b1000000));
        check("first tick frame", 32'(frame), 32'h1);
        cyc(1'b0, 16'h0);
        check("frame one cycle", 32'(frame), 32'h0);

        go_to(1);
        cyc(1'b0, 16'h0);
        cyc(1'b1, 16'h1234);
        go_to(2);
        cyc(1'b0, 16'h0);
        check("no tear d2", 32'(seg), 32'(Z));
        go_to(0);
        cyc(1'b0, 16'h0);
        check("1234 d0", 32'(seg), 32'(7'b0011001));

        go_to(2);
        cyc(1'b1, 16'h0009);
        cyc(1'b0, 16'h0);
        cyc(1'b1, 16'h0042);
        go_to(0);
        cyc(1'b0, 16'h0);
        check("last load d0", 32'(seg), 32'(7'b0100100));
        go_to(1);
        cyc(1'b0, 16'h0);
        check("last load d1", 32'(seg), 32'(7'b0011001));

        for (int r = 0; r < 8; r++) begin
            go_to(0);
            cyc(1'b1, tbl[r].val);
            check($sformatf("tbl%0d an0", r), 32'(an), 32'h0000000E);
            check($sformatf("tbl%0d seg0", r), 32'(seg), 32'(tbl[r].s[0]));
            check($sformatf("tbl%0d frame", r), 32'(frame), 32'h1);
            for (int k = 1; k < 4; k++) begin
                go_to(k);
                cyc(1'b0, 16'h0);
                check($sformatf("tbl%0d an%0d", r, k), 32'(an), 32'(4'(~(4'b0001 << k))));
                check($sformatf("tbl%0d seg%0d", r, k), 32'(seg), 32'(tbl[r].s[k]));
            end
        end

        go_to(2);
        cyc(1'b0, 16'h0);
        cyc(1'b1, 16'h8888);
        #2 rst = 1'b0;
        model_reset();
        #1 check_out("async reset");
        @(negedge clk);
        check_out("held reset");
        rst = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 16'h0);
            checks++;
            if (seg == 7'b0000000) begin
                errors++;
                $display("FAIL discarded pending shown: got seg %b expected not 0000000", seg);
            end
        end

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 7) == 0, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
